// File: rtl/tpu_pkg.sv
// Shared float32 constants, NaN test and feeder state encoding for the TPU feed path.
package tpu_pkg;

    localparam int FP32_W = 32;
    localparam logic [FP32_W-1:0] FP32_ZERO     = 32'h0000_0000;
    localparam logic [FP32_W-1:0] FP32_EXP_MSK  = 32'h7F80_0000;
    localparam logic [FP32_W-1:0] FP32_MANT_MSK = 32'h007F_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feed_state_e;

    // All-ones exponent with a non-zero mantissa; infinities are not NaN.
    function automatic logic fp32_is_nan(input logic [FP32_W-1:0] w);
        return ((w & FP32_EXP_MSK) == FP32_EXP_MSK) && ((w & FP32_MANT_MSK) != '0);
    endfunction

endpackage

// File: rtl/pe_row_skew_feeder_if.sv
// Column-vector stream into the row skew feeder: valid/ready handshake plus tile-end marker.
interface pe_row_skew_feeder_if
    import tpu_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int DW   = FP32_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic                 in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying {valid, data}; shifts every cycle, cleared by async reset.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] taps [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign q = taps[DEPTH-1];
endmodule

// File: rtl/pe_row_skew_feeder.sv
// Skews one float32 column vector per cycle into a diagonal wavefront (row r delayed r+1 cycles).
// Optional macro PE_FEED_NAN_SCRUB_EN replaces NaN words with +0.0 and raises a sticky nan_flag.
module pe_row_skew_feeder
    import tpu_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int DW   = FP32_W
) (
    input  logic                 MCLK,
    input  logic                 RST,
    pe_row_skew_feeder_if.slave  up,
    output logic [ROWS*DW-1:0]   x_feed,
    output logic [ROWS-1:0]      feed_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 nan_flag
);
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(ROWS - 1);

    feed_state_e       state_q, state_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              done_d;
    logic              accept_p0;

    assign up.in_ready = (state_q != DRAIN);
    assign accept_p0   = up.in_valid & up.in_ready;
    assign busy        = (state_q != IDLE);

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            done        <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (accept_p0) begin
                    if (up.in_last) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                // Hold off new vectors until the deepest row has emitted the last one.
                if (drain_cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PE_FEED_NAN_SCRUB_EN
    logic [ROWS-1:0] nan_row_p0;

    function automatic logic [DW-1:0] nan_scrub(input logic [DW-1:0] w);
        return fp32_is_nan(w) ? FP32_ZERO : w;
    endfunction

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST)                             nan_flag <= 1'b0;
        else if (accept_p0 && |nan_row_p0)   nan_flag <= 1'b1;
    end
`else
    assign nan_flag = 1'b0;
`endif

    // Stage p0: per-row word selection; p1..p(r+1): the row's delay line.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DW-1:0] word_p0;
        logic [DW:0]   line_d_p0;
        logic [DW:0]   line_q;

`ifdef PE_FEED_NAN_SCRUB_EN
        assign nan_row_p0[r] = fp32_is_nan(up.in_data[r*DW +: DW]);
        assign word_p0       = nan_scrub(up.in_data[r*DW +: DW]);
`else
        assign word_p0 = up.in_data[r*DW +: DW];
`endif
        // Non-accept cycles push a +0.0 bubble, which is neutral for the downstream MAC.
        assign line_d_p0 = accept_p0 ? {1'b1, word_p0} : {1'b0, FP32_ZERO};

        skew_delay_line #(
            .DEPTH (r + 1),
            .W     (DW + 1)
        ) u_line (
            .clk (MCLK),
            .rst (RST),
            .d   (line_d_p0),
            .q   (line_q)
        );

        assign x_feed[r*DW +: DW] = line_q[DW-1:0];
        assign feed_valid[r]      = line_q[DW];
    end
endmodule

// File: tb/tb_pe_row_skew_feeder.sv
// Directed table-driven bench for pe_row_skew_feeder (ROWS=4), plus NaN and mid-stream reset sequences.
module tb_pe_row_skew_feeder;
    localparam int ROWS = 4;
    localparam int DW   = 32;
`ifdef PE_FEED_NAN_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    logic                MCLK = 1'b0;
    logic                RST;
    logic [ROWS*DW-1:0]  x_feed;
    logic [ROWS-1:0]     feed_valid;
    logic                busy, done, nan_flag;

    pe_row_skew_feeder_if #(.ROWS(ROWS), .DW(DW)) bus ();

    pe_row_skew_feeder #(.ROWS(ROWS), .DW(DW)) dut (
        .MCLK       (MCLK),
        .RST        (RST),
        .up         (bus),
        .x_feed     (x_feed),
        .feed_valid (feed_valid),
        .busy       (busy),
        .done       (done),
        .nan_flag   (nan_flag)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        int   sel;
        logic last;
        logic rdy;
        logic bsy;
        logic dn;
        int   s0, s1, s2, s3;
    } vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [127:0]  vecs [4];
    vec_t          tbl [$];

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int sel, input logic last, input logic rdy, input logic bsy,
                                input logic dn, input int s0, input int s1, input int s2, input int s3);
        vec_t v;
        v.sel = sel; v.last = last; v.rdy = rdy; v.bsy = bsy; v.dn = dn;
        v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3;
        return v;
    endfunction

    function automatic logic [127:0] exp_x(input vec_t v);
        logic [127:0] e;
        int s [4];
        logic [127:0] src;
        s[0] = v.s0; s[1] = v.s1; s[2] = v.s2; s[3] = v.s3;
        e = '0;
        for (int r = 0; r < 4; r++) begin
            if (s[r] >= 0) begin
                src = vecs[s[r]];
                e[r*32 +: 32] = src[r*32 +: 32];
            end
        end
        return e;
    endfunction

    function automatic logic [127:0] exp_v(input vec_t v);
        logic [127:0] e;
        e = '0;
        e[0] = (v.s0 >= 0);
        e[1] = (v.s1 >= 0);
        e[2] = (v.s2 >= 0);
        e[3] = (v.s3 >= 0);
        return e;
    endfunction

    task automatic drive(input int sel, input logic last);
        if (sel >= 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vecs[sel];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        end
        bus.in_last = last;
    endtask

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        vecs[0] = {32'h0000_0000, 32'h3F69_8F1D, 32'h3FFF_BE77, 32'h3F9E_8DB9};
        vecs[1] = {32'h40A0_0000, 32'h4080_0000, 32'h4040_0000, 32'h4000_0000};
        vecs[2] = {32'h4130_0000, 32'h4120_0000, 32'h4110_0000, 32'h4100_0000};
        vecs[3] = {32'h4000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h3F80_0000};

        // Three-vector tile, V2 last
        tbl.push_back(mk( 0, 0, 1, 1, 0,   0, -1, -1, -1));
        tbl.push_back(mk( 1, 0, 1, 1, 0,   1,  0, -1, -1));
        tbl.push_back(mk( 2, 1, 0, 1, 0,   2,  1,  0, -1));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1,  2,  1,  0));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1, -1,  2,  1));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1, -1, -1,  2));
        tbl.push_back(mk(-1, 0, 1, 0, 1,  -1, -1, -1, -1));
        tbl.push_back(mk(-1, 0, 1, 0, 0,  -1, -1, -1, -1));
        // Bubble between V0 and V1
        tbl.push_back(mk( 0, 0, 1, 1, 0,   0, -1, -1, -1));
        tbl.push_back(mk(-1, 0, 1, 1, 0,  -1,  0, -1, -1));
        tbl.push_back(mk( 1, 1, 0, 1, 0,   1, -1,  0, -1));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1,  1, -1,  0));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1, -1,  1, -1));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1, -1, -1,  1));
        tbl.push_back(mk(-1, 0, 1, 0, 1,  -1, -1, -1, -1));
        // Single-vector tile accepted in the done cycle
        tbl.push_back(mk( 2, 1, 0, 1, 0,   2, -1, -1, -1));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1,  2, -1, -1));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1, -1,  2, -1));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1, -1, -1,  2));
        tbl.push_back(mk(-1, 0, 1, 0, 1,  -1, -1, -1, -1));
        tbl.push_back(mk(-1, 0, 1, 0, 0,  -1, -1, -1, -1));
        // in_valid held through DRAIN: V1 ignored until the done cycle
        tbl.push_back(mk( 0, 1, 0, 1, 0,   0, -1, -1, -1));
        tbl.push_back(mk( 1, 0, 0, 1, 0,  -1,  0, -1, -1));
        tbl.push_back(mk( 1, 0, 0, 1, 0,  -1, -1,  0, -1));
        tbl.push_back(mk( 1, 0, 0, 1, 0,  -1, -1, -1,  0));
        tbl.push_back(mk( 1, 0, 1, 0, 1,  -1, -1, -1, -1));
        tbl.push_back(mk( 1, 0, 1, 1, 0,   1, -1, -1, -1));
        tbl.push_back(mk( 2, 1, 0, 1, 0,   2,  1, -1, -1));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1,  2,  1, -1));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1, -1,  2,  1));
        tbl.push_back(mk(-1, 0, 0, 1, 0,  -1, -1, -1,  2));
        tbl.push_back(mk(-1, 0, 1, 0, 1,  -1, -1, -1, -1));
        tbl.push_back(mk(-1, 0, 1, 0, 0,  -1, -1, -1, -1));

        RST = 1'b1;
        drive(-1, 1'b0);
        #12;
        chkw("reset x_feed", x_feed, '0);
        chkw("reset feed_valid", {124'b0, feed_valid}, '0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk1("reset nan_flag", nan_flag, 1'b0);
        chk1("reset in_ready", bus.in_ready, 1'b1);
        @(negedge MCLK);
        RST = 1'b0;
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sel, tbl[i].last);
            step();
            chkw($sformatf("v%0d x_feed", i), x_feed, exp_x(tbl[i]));
            chkw($sformatf("v%0d feed_valid", i), {124'b0, feed_valid}, exp_v(tbl[i]));
            chk1($sformatf("v%0d in_ready", i), bus.in_ready, tbl[i].rdy);
            chk1($sformatf("v%0d busy", i), busy, tbl[i].bsy);
            chk1($sformatf("v%0d done", i), done, tbl[i].dn);
            chk1($sformatf("v%0d nan_flag", i), nan_flag, 1'b0);
        end

        // NaN row 1, +Inf row 2
        drive(3, 1'b1);
        step();
        chk1("nan flag set", nan_flag, SCRUB);
        chkw("nan row0", {96'b0, x_feed[31:0]}, {96'b0, 32'h3F80_0000});
        drive(-1, 1'b0);
        step();
        w = SCRUB ? 32'h0000_0000 : 32'h7FC0_0000;
        chkw("nan row1 word", {96'b0, x_feed[63:32]}, {96'b0, w});
        chk1("nan row1 valid", feed_valid[1], 1'b1);
        step();
        chkw("inf row2 word", {96'b0, x_feed[95:64]}, {96'b0, 32'h7F80_0000});
        chk1("inf row2 valid", feed_valid[2], 1'b1);
        step();
        chkw("nan row3 word", {96'b0, x_feed[127:96]}, {96'b0, 32'h4000_0000});
        step();
        chk1("nan tile done", done, 1'b1);
        step();
        step();
        chk1("nan flag sticky", nan_flag, SCRUB);

        // Reset in the middle of a stream
        drive(0, 1'b0);
        step();
        drive(1, 1'b0);
        step();
        chk1("pre-reset busy", busy, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        chkw("midrst x_feed", x_feed, '0);
        chkw("midrst feed_valid", {124'b0, feed_valid}, '0);
        chk1("midrst busy", busy, 1'b0);
        chk1("midrst done", done, 1'b0);
        chk1("midrst nan_flag", nan_flag, 1'b0);
        chk1("midrst in_ready", bus.in_ready, 1'b1);
        drive(-1, 1'b0);
        @(posedge MCLK);
        @(negedge MCLK);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1($sformatf("postrst%0d done", i), done, 1'b0);
            chkw($sformatf("postrst%0d feed_valid", i), {124'b0, feed_valid}, '0);
        end
        drive(1, 1'b1);
        step();
        chk1("postrst accept in_ready", bus.in_ready, 1'b0);
        chkw("postrst feed_valid", {124'b0, feed_valid}, 128'h1);
        chkw("postrst row0", {96'b0, x_feed[31:0]}, {96'b0, 32'h4000_0000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
